// File: rtl/mem_map_pkg.sv
// Shared memory map: default region bounds, I/O port addresses and the
// access classification produced by the address decoder.
package mem_map_pkg;

  localparam int              MAP_ADDR_W    = 16;
  localparam logic [15:0]     MAP_IMEM_END  = 16'h00FF;
  localparam logic [15:0]     MAP_DMEM_END  = 16'h03FF;
  localparam logic [15:0]     MAP_IN_ADDR   = 16'h0400;
  localparam logic [15:0]     MAP_OUT_ADDR  = 16'h0402;
  localparam logic [15:0]     MAP_MEM_LIMIT = 16'h0800;

  typedef enum logic [2:0] {
    NONE,
    IMEM_RD,
    DMEM_RD,
    DMEM_WR,
    IO_IN,
    IO_OUT,
    ERR
  } access_t;

endpackage

// File: rtl/mem_decode.sv
// Combinational classification of a read/write request against the memory map.
module mem_decode
  import mem_map_pkg::*;
#(
  parameter int               ADDR_W    = MAP_ADDR_W,
  parameter logic [ADDR_W-1:0] IMEM_END  = MAP_IMEM_END,
  parameter logic [ADDR_W-1:0] DMEM_END  = MAP_DMEM_END,
  parameter logic [ADDR_W-1:0] IN_ADDR   = MAP_IN_ADDR,
  parameter logic [ADDR_W-1:0] OUT_ADDR  = MAP_OUT_ADDR,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = MAP_MEM_LIMIT
) (
  input  logic              re_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] address,
  output access_t           access
);

  always_comb begin
    access = NONE;
    if (!re_in && !we_in) begin
      access = NONE;
    // Conflicting, misaligned and out-of-bounds requests fail regardless of region.
    end else if (re_in && we_in) begin
      access = ERR;
    end else if (address[0]) begin
      access = ERR;
    end else if (address >= MEM_LIMIT) begin
      access = ERR;
    end else if (re_in) begin
      if (address <= IMEM_END)      access = IMEM_RD;
      else if (address <= DMEM_END) access = DMEM_RD;
      else if (address == IN_ADDR)  access = IO_IN;
      else                          access = ERR;
    end else begin
      if (address <= IMEM_END)      access = ERR;
      else if (address <= DMEM_END) access = DMEM_WR;
      else if (address == OUT_ADDR) access = IO_OUT;
      else                          access = ERR;
    end
  end

endmodule

// File: rtl/mem_control.sv
// Memory access controller: decodes each request and drives one-hot
// registered enables/strobes, or an error flag, one cycle later.
module mem_control
  import mem_map_pkg::*;
#(
  parameter int               ADDR_W    = MAP_ADDR_W,
  parameter logic [ADDR_W-1:0] IMEM_END  = MAP_IMEM_END,
  parameter logic [ADDR_W-1:0] DMEM_END  = MAP_DMEM_END,
  parameter logic [ADDR_W-1:0] IN_ADDR   = MAP_IN_ADDR,
  parameter logic [ADDR_W-1:0] OUT_ADDR  = MAP_OUT_ADDR,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = MAP_MEM_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] address,
  output logic              mem_err,
  output logic              re_out,
  output logic              we_out,
  output logic              in,
  output logic              out
);

  access_t access_next;

  logic mem_err_reg, re_out_reg, we_out_reg, in_reg, out_reg;
  logic mem_err_next, re_out_next, we_out_next, in_next, out_next;

  mem_decode #(
    .ADDR_W    (ADDR_W),
    .IMEM_END  (IMEM_END),
    .DMEM_END  (DMEM_END),
    .IN_ADDR   (IN_ADDR),
    .OUT_ADDR  (OUT_ADDR),
    .MEM_LIMIT (MEM_LIMIT)
  ) u_decode (
    .re_in   (re_in),
    .we_in   (we_in),
    .address (address),
    .access  (access_next)
  );

  always_comb begin
    mem_err_next = 1'b0;
    re_out_next  = 1'b0;
    we_out_next  = 1'b0;
    in_next      = 1'b0;
    out_next     = 1'b0;
    case (access_next)
      IMEM_RD, DMEM_RD: re_out_next  = 1'b1;
      DMEM_WR:          we_out_next  = 1'b1;
      IO_IN:            in_next      = 1'b1;
      IO_OUT:           out_next     = 1'b1;
      ERR:              mem_err_next = 1'b1;
      default:          ;
    endcase
  end

  // Asynchronous clear so an in-flight strobe drops the instant reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_err_reg <= 1'b0;
      re_out_reg  <= 1'b0;
      we_out_reg  <= 1'b0;
      in_reg      <= 1'b0;
      out_reg     <= 1'b0;
    end else begin
      mem_err_reg <= mem_err_next;
      re_out_reg  <= re_out_next;
      we_out_reg  <= we_out_next;
      in_reg      <= in_next;
      out_reg     <= out_next;
    end
  end

  assign mem_err = mem_err_reg;
  assign re_out  = re_out_reg;
  assign we_out  = we_out_reg;
  assign in      = in_reg;
  assign out     = out_reg;

endmodule

// File: tb/tb_mem_control.sv
// Directed bench for mem_control; outputs compared as {mem_err,re_out,we_out,in,out}.
module tb_mem_control;

  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_ERR  = 5'b10000;
  localparam logic [4:0] E_RD   = 5'b01000;
  localparam logic [4:0] E_WR   = 5'b00100;
  localparam logic [4:0] E_IN   = 5'b00010;
  localparam logic [4:0] E_OUT  = 5'b00001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        re_in, we_in;
  logic [15:0] address;
  logic        mem_err, re_out, we_out, in, out;

  int n_checks = 0;
  int n_fails  = 0;

  mem_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .re_in   (re_in),
    .we_in   (we_in),
    .address (address),
    .mem_err (mem_err),
    .re_out  (re_out),
    .we_out  (we_out),
    .in      (in),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic apply(input string tag, input logic re, input logic we,
                       input logic [15:0] addr, input logic [4:0] exp);
    @(negedge clk);
    re_in   = re;
    we_in   = we;
    address = addr;
    @(posedge clk);
    #1;
    check(tag, {mem_err, re_out, we_out, in, out}, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    re_in   = 1'b1;
    we_in   = 1'b0;
    address = 16'd10;
    #1;
    check("reset_before_clk", {mem_err, re_out, we_out, in, out}, E_IDLE);
    @(posedge clk); #1;
    check("reset_held_over_edge", {mem_err, re_out, we_out, in, out}, E_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    re_in   = 1'b0;

    apply("rd_imem_10",       1'b1, 1'b0, 16'd10,    E_RD);
    apply("rd_misaligned_11", 1'b1, 1'b0, 16'd11,    E_ERR);
    apply("wr_imem_10",       1'b0, 1'b1, 16'd10,    E_ERR);
    apply("rd_dmem_258",      1'b1, 1'b0, 16'd258,   E_RD);
    apply("wr_dmem_258",      1'b0, 1'b1, 16'd258,   E_WR);
    apply("rd_in_1024",       1'b1, 1'b0, 16'd1024,  E_IN);
    apply("wr_out_1026",      1'b0, 1'b1, 16'd1026,  E_OUT);
    apply("wr_in_1024",       1'b0, 1'b1, 16'd1024,  E_ERR);
    apply("rd_out_1026",      1'b1, 1'b0, 16'd1026,  E_ERR);
    apply("wr_oob_2048",      1'b0, 1'b1, 16'd2048,  E_ERR);
    apply("rdwr_both_258",    1'b1, 1'b1, 16'd258,   E_ERR);
    apply("idle_258",         1'b0, 1'b0, 16'd258,   E_IDLE);
    apply("idle_odd_1",       1'b0, 1'b0, 16'd1,     E_IDLE);
    apply("rd_imem_top_fe",   1'b1, 1'b0, 16'h00FE,  E_RD);
    apply("wr_imem_top_fe",   1'b0, 1'b1, 16'h00FE,  E_ERR);
    apply("wr_dmem_low_100",  1'b0, 1'b1, 16'h0100,  E_WR);
    apply("wr_dmem_top_3fe",  1'b0, 1'b1, 16'h03FE,  E_WR);
    apply("rd_dmem_top_3fe",  1'b1, 1'b0, 16'h03FE,  E_RD);
    apply("rd_rsvd_404",      1'b1, 1'b0, 16'h0404,  E_ERR);
    apply("wr_rsvd_7fe",      1'b0, 1'b1, 16'h07FE,  E_ERR);
    apply("rd_oob_fffe",      1'b1, 1'b0, 16'hFFFE,  E_ERR);
    apply("wr_misalign_103",  1'b0, 1'b1, 16'h0103,  E_ERR);
    apply("rd_addr_0",        1'b1, 1'b0, 16'h0000,  E_RD);

    // Reset asserted between edges while a legal read is active.
    apply("rd_before_reset",  1'b1, 1'b0, 16'd10,    E_RD);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async_drop", {mem_err, re_out, we_out, in, out}, E_IDLE);
    @(posedge clk); #1;
    check("reset_hold_edge", {mem_err, re_out, we_out, in, out}, E_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_before_edge", {mem_err, re_out, we_out, in, out}, E_IDLE);
    @(posedge clk); #1;
    check("first_decode_after_release", {mem_err, re_out, we_out, in, out}, E_RD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
